// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack, stall hold buffer, redirect flush.
// Define FETCH_TIMEOUT_EN to add the imem_ack timeout and sticky fetch_err.
module fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] PC_STEP        = 32'd1,
    parameter logic [31:0] NOP_WORD       = {5'b10010, 27'b0},
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pcounter,
    output logic        inst_valid,
    output logic [31:0] fetch_count,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
`ifdef FETCH_TIMEOUT_EN
        ,S_ERR  = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcnt_q, pcnt_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] count_q, count_d;
`ifdef FETCH_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcnt_d       = pcnt_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        count_d      = count_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_d        = tmo_q;
        err_d        = err_q;
`endif
        unique case (state_q)
            S_START: state_d = S_REQ;
            S_REQ: begin
                if (redirect) begin
                    pc_d    = pc_next;
                    instr_d = NOP_WORD;
                    pcnt_d  = pc_next;
                    valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else if (imem_ack) begin
`ifdef FETCH_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (!stall) begin
                        instr_d = imem_rdata;
                        pcnt_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        count_d = count_q + 32'd1;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc_q;
                        state_d      = S_HOLD;
                    end
                end else begin
                    if (!stall) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end
`ifdef FETCH_TIMEOUT_EN
                    tmo_d = tmo_q + 32'd1;
                    if (tmo_d == 32'(TIMEOUT_CYCLES)) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = pc_next;
                    instr_d = NOP_WORD;
                    pcnt_d  = pc_next;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end else if (!stall) begin
                    instr_d = hold_instr_q;
                    pcnt_d  = hold_pc_q;
                    valid_d = 1'b1;
                    pc_d    = hold_pc_q + PC_STEP;
                    count_d = count_q + 32'd1;
                    state_d = S_REQ;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERR: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (redirect) begin
                    pc_d    = pc_next;
                    pcnt_d  = pc_next;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = S_REQ;
                end
            end
`endif
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_START;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_WORD;
            pcnt_q       <= RESET_PC;
            valid_q      <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            count_q      <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcnt_q       <= pcnt_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            count_q      <= count_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_q        <= tmo_d;
            err_q        <= err_d;
`endif
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pcounter    = pcnt_q;
    assign inst_valid  = valid_q;
    assign fetch_count = count_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = err_q;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, ack gaps, stall hold, redirect,
// PC wrap on a second instance, and the optional timeout path.
module tb_fetch_stage;

    localparam logic [31:0] NOP = {5'b10010, 27'b0};

    logic        clk = 1'b0;
    logic        reset, stall, redirect, imem_ack;
    logic [31:0] pc_next, imem_rdata;
    logic        imem_req, inst_valid, fetch_err;
    logic [31:0] imem_addr, instruction, pcounter, fetch_count;

    logic        req2, valid2, err2;
    logic [31:0] addr2, rdata2, instr2, pcnt2, count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .pcounter(pcounter),
        .inst_valid(inst_valid), .fetch_count(fetch_count),
        .fetch_err(fetch_err)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
        .pc_next(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(1'b1), .imem_rdata(rdata2),
        .instruction(instr2), .pcounter(pcnt2),
        .inst_valid(valid2), .fetch_count(count2),
        .fetch_err(err2)
    );

    // Memory model: word at address a is 0x1000_0000 + a.
    assign imem_rdata = 32'h1000_0000 + imem_addr;
    assign rdata2     = 32'h1000_0000 + addr2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic out(input string tag, input logic [31:0] ins,
                       input logic [31:0] pcv, input logic v);
        chk({tag, "_instr"}, instruction, ins);
        chk({tag, "_pc"}, pcounter, pcv);
        chk({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, v});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0;
        imem_ack = 1'b0; pc_next = '0;
        tick;
        tick;
        out("rst", NOP, 32'h0, 1'b0);
        chk("rst_cnt", fetch_count, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);

        reset = 1'b0; imem_ack = 1'b1;
        tick;
        chk("start_req", {31'b0, imem_req}, 32'd1);
        chk("start_addr", imem_addr, 32'h0);
        chk("w_addr0", addr2, 32'hFFFF_FFFF);

        for (int i = 0; i < 4; i++) begin
            tick;
            out($sformatf("seq%0d", i), 32'h1000_0000 + i, i, 1'b1);
            chk($sformatf("seq%0d_addr", i), imem_addr, i + 1);
            if (i == 0) begin
                chk("w_addr1", addr2, 32'h0);
                chk("w_pc0", pcnt2, 32'hFFFF_FFFF);
                chk("w_ins0", instr2, 32'h0FFF_FFFF);
            end
            if (i == 1) begin
                chk("w_pc1", pcnt2, 32'h0);
                chk("w_cnt", count2, 32'd2);
                chk("w_err", {31'b0, err2}, 32'd0);
            end
        end
        chk("seq_cnt", fetch_count, 32'd4);

        tick;
        out("pc4", 32'h1000_0004, 32'd4, 1'b1);

        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            out($sformatf("gap%0d", i), NOP, 32'd4, 1'b0);
            chk($sformatf("gap%0d_addr", i), imem_addr, 32'd5);
        end
        chk("gap_err", {31'b0, fetch_err}, 32'd0);
        imem_ack = 1'b1;
        tick;
        out("pc5", 32'h1000_0005, 32'd5, 1'b1);
        tick;
        out("pc6", 32'h1000_0006, 32'd6, 1'b1);
        chk("pc6_addr", imem_addr, 32'd7);

        stall = 1'b1;
        tick;
        out("st0", 32'h1000_0006, 32'd6, 1'b1);
        chk("st0_req", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick;
            out($sformatf("st%0d", i), 32'h1000_0006, 32'd6, 1'b1);
            chk($sformatf("st%0d_req", i), {31'b0, imem_req}, 32'd0);
        end
        chk("st_cnt", fetch_count, 32'd7);
        stall = 1'b0;
        tick;
        out("rel", 32'h1000_0007, 32'd7, 1'b1);
        chk("rel_addr", imem_addr, 32'd8);
        chk("rel_cnt", fetch_count, 32'd8);

        imem_ack = 1'b1;
        tick;
        out("pc8", 32'h1000_0008, 32'd8, 1'b1);
        chk("pc8_addr", imem_addr, 32'd9);

        redirect = 1'b1; pc_next = 32'h40;
        tick;
        out("redir", NOP, 32'h40, 1'b0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_cnt", fetch_count, 32'd9);
        redirect = 1'b0;
        tick;
        out("tgt", 32'h1000_0040, 32'h40, 1'b1);
        chk("tgt_cnt", fetch_count, 32'd10);

        // Redirect wins over stall.
        stall = 1'b1; redirect = 1'b1; pc_next = 32'h80;
        tick;
        out("rs", NOP, 32'h80, 1'b0);
        chk("rs_addr", imem_addr, 32'h80);
        stall = 1'b0; redirect = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        imem_ack = 1'b0;
        for (int i = 0; i < 15; i++) tick;
        chk("to_pre", {31'b0, fetch_err}, 32'd0);
        tick;
        chk("to_err", {31'b0, fetch_err}, 32'd1);
        chk("to_req", {31'b0, imem_req}, 32'd0);
        redirect = 1'b1; pc_next = 32'h0;
        tick;
        redirect = 1'b0;
        chk("to_clr", {31'b0, fetch_err}, 32'd0);
        chk("to_req1", {31'b0, imem_req}, 32'd1);
`else
        imem_ack = 1'b0;
        for (int i = 0; i < 20; i++) tick;
        chk("noto_err", {31'b0, fetch_err}, 32'd0);
        chk("noto_req", {31'b0, imem_req}, 32'd1);
`endif

        // Reset mid-transfer with ack pending.
        imem_ack = 1'b1; reset = 1'b1;
        tick;
        out("rst2", NOP, 32'h0, 1'b0);
        chk("rst2_cnt", fetch_count, 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage, directly upstream of the decode/execute stage.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake.
- Registers {instruction, pcounter} for decode.
- Accepts stall and redirect (pc_next from decode/execute); inserts NOP bubbles when no instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 1, PC increment per fetched instruction (word-addressed)
- NOP_WORD, {5'b10010,27'b0}, bubble encoding (opcode NOP = 5'b10010)
- TIMEOUT_CYCLES, 16, wait limit for imem_ack (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept a new instruction this cycle
- redirect  in  1  take branch/jump; flush stage
- pc_next  in  32  redirect target, valid when redirect=1
- imem_req  out  1  read request
- imem_addr  out  32  read address (= pc register)
- imem_ack  in  1  read data valid this cycle; sampled only when imem_req=1
- imem_rdata  in  32  instruction word
- instruction  out  32  registered instruction to decode
- pcounter  out  32  registered PC of the instruction
- inst_valid  out  1  instruction/pcounter hold a real fetched instruction
- fetch_count  out  32  number of instructions delivered to decode (wraps)
- fetch_err  out  1  fetch timeout flag (see Optional Feature)

Behaviour:
- Reset (reset=1 at an edge):
  - pc=RESET_PC, state=S_START
  - instruction=NOP_WORD, pcounter=RESET_PC, inst_valid=0
  - hold buffer empty, fetch_count=0, fetch_err=0
- Reset overrides every other input, including mid-transfer; any pending ack is ignored.
- imem_req and imem_addr are combinational from state/pc:
  - imem_req=1 only in S_REQ.
  - imem_addr=pc at all times.
- S_START: imem_req=0; next cycle go to S_REQ. The first request appears the cycle after reset deasserts.
- S_REQ, evaluated each edge in priority order:
  1. redirect=1:
     - pc<=pc_next; outputs<=NOP_WORD/inst_valid=0 (pcounter<=pc_next).
     - Any same-cycle ack is consumed and discarded; stay in S_REQ.
     - Redirect overrides stall.
  2. imem_ack=1, stall=0:
     - instruction<=imem_rdata, pcounter<=pc, inst_valid<=1.
     - pc<=pc+PC_STEP, fetch_count+1.
     - Stay in S_REQ, so back-to-back fetches give 1 instruction/cycle.
  3. imem_ack=1, stall=1:
     - Capture imem_rdata and pc into the hold buffer; outputs unchanged.
     - Go to S_HOLD.
  4. imem_ack=0, stall=0: outputs<=NOP_WORD, inst_valid<=0; pcounter unchanged.
  5. imem_ack=0, stall=1: outputs unchanged.
- S_HOLD:
  - imem_req=0.
  - redirect=1: discard buffer, apply the redirect as above, go to S_REQ.
  - stall=0: outputs<=buffer (inst_valid=1), pc<=buffered pc+PC_STEP, fetch_count+1, go to S_REQ.
  - stall=1: remain; all outputs held.
- Stall holds instruction/pcounter/inst_valid stable for its whole duration, so decode sees the same values.
- Arithmetic:
  - pc+PC_STEP is modulo 2^32: 32'hFFFF_FFFF+1 = 0, with no error.
  - fetch_count wraps modulo 2^32.
- Latency: memory ack in cycle N means instruction is visible at decode in cycle N+1, when not stalled.
- At most one outstanding read; no instruction is ever duplicated or dropped, except on redirect/reset flush.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter increments every S_REQ cycle without ack and clears on ack, redirect, or reset.
  - When it reaches TIMEOUT_CYCLES, fetch_err<=1 (sticky) and state goes to S_ERR.
  - S_ERR: imem_req=0, outputs NOP_WORD/inst_valid=0.
  - Exit S_ERR only by reset, or by redirect (which clears fetch_err and goes to S_REQ).
- Not defined: fetch_err is tied to 0; no counter or S_ERR logic is synthesized.

Test Plan:
- Reset then ack every cycle with rdata=32'h1000_0000+addr, stall=0 -> imem_addr 0,1,2,3; instruction 32'h1000_0000, 32'h1000_0001… one cycle later; pcounter 0,1,2; inst_valid=1; fetch_count=4 after 4 acks.
- Ack withheld 3 cycles at pc=5 -> three outputs NOP_WORD with inst_valid=0 and pcounter held; then ack -> instruction at pcounter=5.
- stall=1 for 4 cycles while ack arrives at pc=7 -> outputs frozen, imem_req=0 after capture; on release, pcounter=7 with buffered word, next imem_addr=8.
- redirect=1 with pc_next=32'h40 in the same cycle as ack at pc=9 -> word discarded; outputs NOP_WORD/inst_valid=0; next imem_addr=32'h40; fetch_count unchanged.
- RESET_PC=32'hFFFF_FFFF, ack each cycle -> addresses FFFF_FFFF then 0000_0000; no error; fetch_count increments.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> fetch_err=1 after 16 request cycles and imem_req=0; redirect pc_next=0 -> fetch_err=0, imem_req=1. Without the macro, fetch_err stays 0 throughout.
